mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- RV32I memory-access stage; consumes the registered EX/MEM outputs (ALU result, RS2, WB/MEM controls) and drives the data-memory request/grant/response bus.
- Performs load/store byte-lane alignment, load sign/zero extension and stall generation toward the hazard unit.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance from hazard unit; MEM/WB captures only when en=1.
- alu_out_in  in  32  effective address, or ALU result for non-memory ops.
- rs2_in  in  32  store data.
- rd_in  in  5  destination register.
- funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_val_in  in  1  instruction performs a memory access.
- mem_rw_in  in  1  1=store, 0=load.
- wb_sel_in  in  1  1=write back load data, 0=write back ALU result.
- register_write_enable_in  in  1  register-file write enable.
- dmem_req  out  1  access request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  ADDR_W  word-aligned address; bits [1:0]=00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- stall  out  1  access not yet complete; hazard unit freezes PC through EX/MEM.
- alu_out_out  out  32  registered ALU result.
- mem_data_out  out  32  registered, extended load data.
- rd_out  out  5  registered rd.
- wb_sel_out  out  1  registered wb_sel.
- register_write_enable_out  out  1  registered write enable.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all registered outputs 0; dmem_req=0; any later rvalid is ignored until a new load is granted.
- FSM states:
  - IDLE: dmem_req = mem_val_in (combinational, same cycle the instruction is present).
    - Store with gnt: complete.
    - Load with gnt and rvalid in the same cycle: complete.
    - Load with gnt, no rvalid: go to WAIT_R.
    - No gnt: stay in IDLE, keep dmem_req high with stable address/data/be.
  - WAIT_R: dmem_req=0. On rvalid: complete.
  - DONE: entered when completion occurs while en=0. Holds the extended load data in an internal buffer; no re-request. Returns to IDLE on the first cycle with en=1.
- stall = mem_val_in & ~complete_this_cycle & (state != DONE). Non-memory instructions never stall.
- MEM/WB capture:
  - en=1 and stall=0: capture all inputs; mem_data_out = extended dmem_rdata, or the DONE buffer.
  - en=1 and stall=1: insert bubble (register_write_enable_out=0, rd_out=0).
  - en=0: hold all outputs.
- Store lanes, with a = alu_out_in[1:0]:
  - SB: be = 0001<<a; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<{a[1],0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- Load extract: byte at lane a, or halfword at lane a[1]; sign-extend for B/H, zero-extend for BU/HU; W passes the word through.
- funct3 codes 011, 110, 111 are treated as W.
- Loads drive dmem_we=0 and dmem_be=1111.
- Latency: zero-wait memory (gnt and rvalid in the request cycle) gives no stall; the result appears in MEM/WB one edge later.
- Mid-operation reset aborts the access; no partial write-back occurs.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - H access with a[0]=1 or W access with a!=00 issues no request and causes no stall.
  - Extra port misalign_out (out, 1, registered) is 1 for that instruction in MEM/WB, with register_write_enable_out forced to 0.
- Undefined:
  - Offending low address bits are ignored; the access proceeds to the naturally aligned halfword or word.
  - No misalign_out port.

Decomposition:
- Package mem_pkg: funct3 size/sign constants, FSM state encoding (IDLE/WAIT_R/DONE), byte-enable constants.
- Sub-module mem_lane_align: combinational store be/wdata generation and load extract/extend. The FSM and MEM/WB register stay in mem_stage.

Test Plan:
- Reset: rst=0 mid-load in WAIT_R -> state IDLE, dmem_req=0, all outputs 0; a later rvalid causes no write-back.
- SW at 0x100, rs2=0xDEADBEEF, gnt in the same cycle -> single req cycle, dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, stall=0.
- SB at 0x101, rs2=0x000000AB -> be=0010, wdata=0xABABABAB.
- LB at 0x103, gnt at cycle 0, rvalid at cycle 2 with rdata=0x80112233 -> stall=1 for cycles 0-1, then mem_data_out=0xFFFFFF80.
- LHU at 0x102, rdata=0xBEEF1234 -> mem_data_out=0x0000BEEF.
- Load completes while en=0 -> DONE, exactly one dmem_req pulse, stall=0; on en=1, mem_data_out holds the buffered value.
- (With MEM_MISALIGN_TRAP_EN) LW at 0x102 -> no req, misalign_out=1, register_write_enable_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the RV32I memory stage: access sizes, byte enables, FSM states.
// Helper access_size folds the undefined funct3 codes onto word accesses.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // funct3 bit that selects zero-extension for byte/halfword loads
  localparam int F3_UNSIGNED_BIT = 2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data, load extract and extend.
// Zero latency; no flow control of its own.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_be,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data
);

  logic [1:0]  size;
  logic        is_unsigned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    size        = access_size(funct3);
    is_unsigned = funct3[F3_UNSIGNED_BIT];

    case (addr_lo)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    case (size)
      SZ_B: begin
        store_be    = BE_BYTE << addr_lo;
        store_wdata = {4{store_data[7:0]}};
        load_data   = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      end
      SZ_H: begin
        store_be    = BE_HALF << {addr_lo[1], 1'b0};
        store_wdata = {2{store_data[15:0]}};
        load_data   = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      end
      default: begin
        store_be    = BE_WORD;
        store_wdata = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory request FSM, lane alignment and MEM/WB register (one edge to MEM/WB).
// Stalls until the access completes; MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into traps.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [XLEN-1:0]   alu_out_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic [4:0]        rd_in,
  input  logic [2:0]        funct3_in,
  input  logic              mem_val_in,
  input  logic              mem_rw_in,
  input  logic              wb_sel_in,
  input  logic              register_write_enable_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic [XLEN-1:0]   alu_out_out,
  output logic [XLEN-1:0]   mem_data_out,
  output logic [4:0]        rd_out,
  output logic              wb_sel_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_out,
`endif
  output logic              register_write_enable_out
);

  mem_state_t  state;
  logic [31:0] ld_buf;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;
  logic [31:0] ld_result;
  logic        misaligned;
  logic        access;
  logic        is_load;
  logic        is_store;
  logic        complete;

  mem_lane_align u_align (
    .funct3      (funct3_in),
    .addr_lo     (alu_out_in[1:0]),
    .store_data  (rs2_in),
    .load_word   (dmem_rdata),
    .store_be    (st_be),
    .store_wdata (st_wdata),
    .load_data   (ld_ext)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (access_size(funct3_in))
      SZ_H:    misaligned = mem_val_in & alu_out_in[0];
      SZ_W:    misaligned = mem_val_in & (alu_out_in[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign access   = mem_val_in & ~misaligned;
  assign is_load  = access & ~mem_rw_in;
  assign is_store = access & mem_rw_in;

  // A trapped access counts as complete so it never holds up the pipe
  always_comb begin
    case (state)
      IDLE:    complete = misaligned | (dmem_gnt & (is_store | (is_load & dmem_rvalid)));
      WAIT_R:  complete = dmem_rvalid;
      default: complete = 1'b0;
    endcase
  end

  assign stall      = mem_val_in & ~complete & (state != DONE);
  assign dmem_req   = (state == IDLE) & access;
  assign dmem_we    = dmem_req & mem_rw_in;
  assign dmem_addr  = {alu_out_in[ADDR_W-1:2], 2'b00};
  assign dmem_be    = mem_rw_in ? st_be : BE_WORD;
  assign dmem_wdata = st_wdata;
  assign ld_result  = (state == DONE) ? ld_buf : ld_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ld_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && dmem_gnt) begin
            if (!complete) begin
              state <= WAIT_R;
            end else if (!en) begin
              state  <= DONE;
              ld_buf <= ld_ext;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            if (en) begin
              state <= IDLE;
            end else begin
              state  <= DONE;
              ld_buf <= ld_ext;
            end
          end
        end
        DONE: begin
          if (en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-load instructions write zero into mem_data_out so stray rvalid data never leaks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out_out               <= '0;
      mem_data_out              <= '0;
      rd_out                    <= '0;
      wb_sel_out                <= 1'b0;
      register_write_enable_out <= 1'b0;
    end else if (en) begin
      if (stall) begin
        rd_out                    <= '0;
        register_write_enable_out <= 1'b0;
      end else begin
        alu_out_out               <= alu_out_in;
        mem_data_out              <= is_load ? ld_result : '0;
        rd_out                    <= rd_in;
        wb_sel_out                <= wb_sel_in;
        register_write_enable_out <= register_write_enable_in & ~misaligned;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_out <= 1'b0;
    end else if (en) begin
      misalign_out <= ~stall & misaligned;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus random bench for mem_stage against a transaction-level reference model.
// Each instruction is scheduled (grant delay, rvalid delay, en holds) and expectations derive from that schedule.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] alu_out_in;
  logic [31:0] rs2_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        mem_val_in;
  logic        mem_rw_in;
  logic        wb_sel_in;
  logic        register_write_enable_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] alu_out_out;
  logic [31:0] mem_data_out;
  logic [4:0]  rd_out;
  logic        wb_sel_out;
  logic        register_write_enable_out;
  logic        misalign_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_alu, m_mem;
  logic [4:0]  m_rd;
  logic        m_wbs, m_we, m_mis;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .en                        (en),
    .alu_out_in                (alu_out_in),
    .rs2_in                    (rs2_in),
    .rd_in                     (rd_in),
    .funct3_in                 (funct3_in),
    .mem_val_in                (mem_val_in),
    .mem_rw_in                 (mem_rw_in),
    .wb_sel_in                 (wb_sel_in),
    .register_write_enable_in  (register_write_enable_in),
    .dmem_req                  (dmem_req),
    .dmem_we                   (dmem_we),
    .dmem_addr                 (dmem_addr),
    .dmem_be                   (dmem_be),
    .dmem_wdata                (dmem_wdata),
    .dmem_gnt                  (dmem_gnt),
    .dmem_rvalid               (dmem_rvalid),
    .dmem_rdata                (dmem_rdata),
    .stall                     (stall),
    .alu_out_out               (alu_out_out),
    .mem_data_out              (mem_data_out),
    .rd_out                    (rd_out),
    .wb_sel_out                (wb_sel_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_out              (misalign_out),
`endif
    .register_write_enable_out (register_write_enable_out)
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign misalign_out = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = byte, 1 = halfword, 2 = word
  function automatic int size_ref(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 0;
      3'b001, 3'b101: return 1;
      default:        return 2;
    endcase
  endfunction

  function automatic bit misaligned_ref(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (size_ref(f3) == 1) return a[0];
    if (size_ref(f3) == 2) return a != 2'b00;
    return 1'b0;
`else
    return (f3 == 3'b111) && (a == 2'b11) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] be_ref(input logic [2:0] f3, input logic [1:0] a);
    int sz;
    sz = size_ref(f3);
    if (sz == 0) return 4'(1 << a);
    if (sz == 1) return 4'(3 << (a & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_ref(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = size_ref(f3);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check_wb();
    chk("alu_out_out", alu_out_out, m_alu);
    chk("mem_data_out", mem_data_out, m_mem);
    chk("rd_out", {27'b0, rd_out}, {27'b0, m_rd});
    chk("wb_sel_out", {31'b0, wb_sel_out}, {31'b0, m_wbs});
    chk("reg_we_out", {31'b0, register_write_enable_out}, {31'b0, m_we});
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalign_out", {31'b0, misalign_out}, {31'b0, m_mis});
`endif
  endtask

  // Runs one instruction from posedge+1 to the posedge+1 after its final cycle.
  // gd: cycles before grant; rdly: cycles from grant to rvalid; hold: en=0 cycles after completion.
  task automatic run_instr(input bit mem, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rword,
                           input int gd, input int rdly, input int hold, input bit rand_en);
    bit          mis, ld, ereq, estall, e_en, wbs, wev;
    int          c_done;
    logic [31:0] exp_ld;
    logic [4:0]  rdv;
    rdv    = 5'($urandom);
    wbs    = 1'($urandom);
    wev    = 1'($urandom);
    mis    = mem && misaligned_ref(f3, addr[1:0]);
    ld     = mem && !st && !mis;
    c_done = (!mem || mis) ? 0 : (st ? gd : gd + rdly);
    exp_ld = ld ? load_ref(f3, addr[1:0], rword) : 32'h0;
    for (int c = 0; c <= c_done + hold; c++) begin
      mem_val_in               = mem;
      mem_rw_in                = st;
      funct3_in                = f3;
      alu_out_in               = addr;
      rs2_in                   = data;
      rd_in                    = rdv;
      wb_sel_in                = wbs;
      register_write_enable_in = wev;
      dmem_gnt                 = mem && !mis && (c == gd);
      dmem_rvalid              = ld && (c == gd + rdly);
      dmem_rdata               = dmem_rvalid ? rword : $urandom;
      if (c < c_done) e_en = rand_en ? 1'($urandom) : 1'b1;
      else            e_en = (c == c_done + hold);
      en     = e_en;
      ereq   = mem && !mis && (c <= gd);
      estall = mem && !mis && (c < c_done);
      @(negedge clk);
      check_wb();
      chk("dmem_req", {31'b0, dmem_req}, {31'b0, ereq});
      chk("stall", {31'b0, stall}, {31'b0, estall});
      chk("dmem_we", {31'b0, dmem_we}, {31'b0, ereq && st});
      if (ereq) begin
        chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("dmem_be", {28'b0, dmem_be}, {28'b0, st ? be_ref(f3, addr[1:0]) : 4'hF});
        if (st) chk("dmem_wdata", dmem_wdata, wdata_ref(f3, data));
      end
      if (e_en) begin
        if (estall) begin
          m_we  = 1'b0;
          m_rd  = 5'd0;
          m_mis = 1'b0;
        end else begin
          m_alu = addr;
          m_rd  = rdv;
          m_wbs = wbs;
          m_we  = wev && !mis;
          m_mem = exp_ld;
          m_mis = mis;
        end
      end
      @(posedge clk);
      #1;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    int          kind;
    logic [2:0]  f3;
    rst = 1'b0; en = 1'b0;
    alu_out_in = '0; rs2_in = '0; rd_in = '0; funct3_in = '0;
    mem_val_in = 1'b0; mem_rw_in = 1'b0; wb_sel_in = 1'b0; register_write_enable_in = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    m_alu = '0; m_mem = '0; m_rd = '0; m_wbs = 1'b0; m_we = 1'b0; m_mis = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_wb();
    chk("reset dmem_req", {31'b0, dmem_req}, 32'h0);
    chk("reset stall", {31'b0, stall}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // SW 0x100, SB 0x101, LB 0x103 slow, LHU 0x102
    run_instr(1, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0);
    run_instr(1, 1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 0, 0, 0, 0);
    run_instr(1, 0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 2, 0, 0);
    chk("lb sign-extend", mem_data_out, 32'hFFFF_FF80);
    run_instr(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0);
    chk("lhu zero-extend", mem_data_out, 32'h0000_BEEF);

    // load completes while en=0, then buffered value released
    run_instr(1, 0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1, 1, 2, 0);
    chk("done buffer", mem_data_out, 32'h1234_5678);

    // reset while waiting for rvalid
    mem_val_in = 1'b1; mem_rw_in = 1'b0; funct3_in = 3'b000; alu_out_in = 32'h103;
    rd_in = 5'd7; wb_sel_in = 1'b1; register_write_enable_in = 1'b1;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("pre-reset req", {31'b0, dmem_req}, 32'h1);
    chk("pre-reset stall", {31'b0, stall}, 32'h1);
    m_we = 1'b0; m_rd = 5'd0;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    chk("wait_r req", {31'b0, dmem_req}, 32'h0);
    rst = 1'b0;
    mem_val_in = 1'b0; alu_out_in = '0; rd_in = '0; wb_sel_in = 1'b0; register_write_enable_in = 1'b0;
    m_alu = '0; m_mem = '0; m_rd = '0; m_wbs = 1'b0; m_we = 1'b0; m_mis = 1'b0;
    #1;
    check_wb();
    chk("midreset req", {31'b0, dmem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = $urandom;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check_wb();
    @(posedge clk);
    #1;
    run_instr(1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 0);
    chk("post-reset load", mem_data_out, 32'hCAFE_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
    run_instr(1, 0, 3'b010, 32'h102, 32'h0, 32'h5555_AAAA, 0, 0, 0, 0);
    chk("trap misalign_out", {31'b0, misalign_out}, 32'h1);
    chk("trap reg_we_out", {31'b0, register_write_enable_out}, 32'h0);
`endif

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) f3 = 3'($urandom_range(0, 3));
      else           f3 = 3'($urandom);
      run_instr(kind != 0, kind == 1, f3, $urandom, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, 1'b1);
    end

    mem_val_in = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check_wb();
    chk("idle stall", {31'b0, stall}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
